// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 16-bit RISC pipeline. Holds the PC, fetches from
// instruction memory and fills the IF/ID register, honouring stalls and redirects.
`default_nettype none

module fetch_stage #(
  parameter int               PC_W     = 16,
  parameter int               IR_W     = 16,
  parameter logic [PC_W-1:0]  RESET_PC = 16'h0000,
  parameter logic [IR_W-1:0]  NOP_IR   = 16'hF000
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] pc_out,
  input  logic [IR_W-1:0] ir_in,
  input  logic            stall,
  input  logic            id_redirect,
  input  logic [PC_W-1:0] id_target,
  input  logic            ex_redirect,
  input  logic [PC_W-1:0] ex_target,
  output logic [IR_W-1:0] ir_fd,
  output logic [PC_W-1:0] pc_fd,
  output logic [PC_W-1:0] pc_inc_fd,
  output logic            valid_fd
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [IR_W-1:0] ir_fd_q, ir_fd_d;
  logic [PC_W-1:0] pc_fd_q, pc_fd_d;
  logic [PC_W-1:0] pc_inc_fd_q, pc_inc_fd_d;
  logic            valid_fd_q, valid_fd_d;
  logic [PC_W-1:0] pc_plus1;

  // Wraps modulo 2^PC_W by construction of the width.
  assign pc_plus1 = pc_q + PC_W'(1);

  always_comb begin
    pc_d        = pc_q;
    ir_fd_d     = ir_fd_q;
    pc_fd_d     = pc_fd_q;
    pc_inc_fd_d = pc_inc_fd_q;
    valid_fd_d  = valid_fd_q;

    if (ex_redirect) begin
      // EX branch wins even over a stall: everything younger is wrong-path.
      pc_d       = ex_target;
      ir_fd_d    = NOP_IR;
      valid_fd_d = 1'b0;
    end else if (stall) begin
      // Hold; a pending ID jump is re-asserted by ID once the stall clears.
      pc_d = pc_q;
    end else if (id_redirect) begin
      pc_d       = id_target;
      ir_fd_d    = NOP_IR;
      valid_fd_d = 1'b0;
    end else begin
      pc_d        = pc_plus1;
      ir_fd_d     = ir_in;
      pc_fd_d     = pc_q;
      pc_inc_fd_d = pc_plus1;
      valid_fd_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      ir_fd_q     <= NOP_IR;
      pc_fd_q     <= '0;
      pc_inc_fd_q <= '0;
      valid_fd_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ir_fd_q     <= ir_fd_d;
      pc_fd_q     <= pc_fd_d;
      pc_inc_fd_q <= pc_inc_fd_d;
      valid_fd_q  <= valid_fd_d;
    end
  end

  assign pc_out    = pc_q;
  assign ir_fd     = ir_fd_q;
  assign pc_fd     = pc_fd_q;
  assign pc_inc_fd = pc_inc_fd_q;
  assign valid_fd  = valid_fd_q;

endmodule

`default_nettype wire
